// File: rtl/clas_bias_argmax.sv
// Classifier tail: adds per-class LUT bias to streamed MAC accumulations and keeps a running argmax.
// Optional macro CLAS_LOGITS_EN adds a per-class logit readout port (logits_o).
module clas_bias_argmax #(
  parameter int ACC_WIDTH  = 20,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_CLASS  = 6,
  parameter int BIAS_SHIFT = 0,
  parameter logic [ADDR_WIDTH-1:0] BIAS_ADDR = 8'h01
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         acc_valid,
  input  logic signed [ACC_WIDTH-1:0]  acc_data,
  output logic                         acc_ready,
  output logic [ADDR_WIDTH-1:0]        lut_addr,
  input  logic signed [DATA_WIDTH-1:0] bias_i [0:NUM_CLASS-1],
  output logic [2:0]                   class_o,
  output logic                         class_valid,
  input  logic                         class_ready,
  output logic                         busy_o
`ifdef CLAS_LOGITS_EN
  ,
  output logic signed [ACC_WIDTH:0]    logits_o [0:NUM_CLASS-1]
`endif
);

  localparam int LW = ACC_WIDTH + 1;
  localparam logic [2:0] LAST_IDX = 3'(NUM_CLASS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESULT} state_t;

  state_t                r_state;
  logic [2:0]            r_idx;
  logic [2:0]            r_best;
  logic [2:0]            r_class;
  logic signed [LW-1:0]  r_max;
  logic                  r_class_valid;
  logic                  r_acc_ready;
  logic                  r_busy;

  logic                  w_beat;
  logic signed [LW-1:0]  w_logit;
  logic                  w_gt;

  // One guard bit above the accumulator absorbs the bias add, so no saturation is needed.
  function automatic logic signed [LW-1:0] f_logit(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] bias
  );
    logic signed [LW-1:0] acc_x;
    logic signed [LW-1:0] bias_x;
    acc_x  = {acc[ACC_WIDTH-1], acc};
    bias_x = {{(LW-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    return acc_x + (bias_x <<< BIAS_SHIFT);
  endfunction

  assign lut_addr = BIAS_ADDR;
  assign w_beat   = acc_valid & r_acc_ready;
  assign w_logit  = f_logit(acc_data, bias_i[r_idx]);
  // Strict compare: equal logits leave the earlier (lower) class as winner.
  assign w_gt     = w_logit > r_max;

`ifdef CLAS_LOGITS_EN
  logic signed [LW-1:0] r_logits [0:NUM_CLASS-1];
  assign logits_o = r_logits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CLASS; k++) r_logits[k] <= '0;
    end else if (w_beat) begin
      r_logits[r_idx] <= w_logit;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_best        <= '0;
      r_class       <= '0;
      r_max         <= '0;
      r_class_valid <= 1'b0;
      r_acc_ready   <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_beat) begin
            r_idx   <= 3'd1;
            r_max   <= w_logit;
            r_best  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_beat) begin
            if (w_gt) begin
              r_max  <= w_logit;
              r_best <= r_idx;
            end
            r_idx <= r_idx + 3'd1;
            if (r_idx == LAST_IDX) begin
              r_idx         <= '0;
              r_class       <= w_gt ? r_idx : r_best;
              r_class_valid <= 1'b1;
              r_acc_ready   <= 1'b0;
              r_state       <= S_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (class_ready) begin
            r_class_valid <= 1'b0;
            r_acc_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_class_valid <= 1'b0;
          r_acc_ready   <= 1'b1;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign acc_ready   = r_acc_ready;
  assign class_o     = r_class;
  assign class_valid = r_class_valid;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_clas_bias_argmax.sv
// Directed bench for clas_bias_argmax: two instances (BIAS_SHIFT=0 and 4) share one stimulus stream.
module tb_clas_bias_argmax;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               acc_valid = 1'b0;
  logic signed [19:0] acc_data = '0;
  logic               class_ready = 1'b0;
  logic signed [7:0]  bias [0:5];

  logic       acc_ready0, acc_ready4;
  logic [7:0] lut_addr0, lut_addr4;
  logic [2:0] class0, class4;
  logic       cv0, cv4;
  logic       busy0, busy4;
`ifdef CLAS_LOGITS_EN
  logic signed [20:0] logits0 [0:5];
  logic signed [20:0] logits4 [0:5];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clas_bias_argmax #(.BIAS_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .acc_data(acc_data),
    .acc_ready(acc_ready0), .lut_addr(lut_addr0), .bias_i(bias),
    .class_o(class0), .class_valid(cv0), .class_ready(class_ready), .busy_o(busy0)
`ifdef CLAS_LOGITS_EN
    , .logits_o(logits0)
`endif
  );

  clas_bias_argmax #(.BIAS_SHIFT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .acc_data(acc_data),
    .acc_ready(acc_ready4), .lut_addr(lut_addr4), .bias_i(bias),
    .class_o(class4), .class_valid(cv4), .class_ready(class_ready), .busy_o(busy4)
`ifdef CLAS_LOGITS_EN
    , .logits_o(logits4)
`endif
  );

  typedef struct packed {
    logic [5:0][19:0] acc;
    logic [2:0]       exp0;
    logic [2:0]       exp4;
  } vec_t;

  vec_t vecs [0:15];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int a0, input int a1, input int a2,
                         input int a3, input int a4, input int a5,
                         input int e0, input int e4);
    vecs[i].acc[0] = 20'(a0);
    vecs[i].acc[1] = 20'(a1);
    vecs[i].acc[2] = 20'(a2);
    vecs[i].acc[3] = 20'(a3);
    vecs[i].acc[4] = 20'(a4);
    vecs[i].acc[5] = 20'(a5);
    vecs[i].exp0   = 3'(e0);
    vecs[i].exp4   = 3'(e4);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_cv0"}, int'(cv0), 0);
    chk({tag, "_cv4"}, int'(cv4), 0);
    chk({tag, "_rdy0"}, int'(acc_ready0), 1);
    chk({tag, "_rdy4"}, int'(acc_ready4), 1);
    chk({tag, "_busy0"}, int'(busy0), 0);
    chk({tag, "_busy4"}, int'(busy4), 0);
  endtask

  // Drives six beats (optionally with idle gaps carrying junk data) and checks the result cycle.
  task automatic run_frame(input int i, input bit gap);
    for (int k = 0; k < 6; k++) begin
      acc_valid = 1'b1;
      acc_data  = $signed(vecs[i].acc[k]);
      @(posedge clk); #1;
      if (k < 5) begin
        chk($sformatf("v%0d_b%0d_cv_early", i, k), int'(cv0), 0);
        chk($sformatf("v%0d_b%0d_busy", i, k), int'(busy0), 1);
        if (gap) begin
          acc_valid = 1'b0;
          acc_data  = 20'sd300000;
          repeat (2) @(posedge clk);
          #1;
        end
      end
    end
    acc_valid = 1'b0;
    acc_data  = '0;
    chk($sformatf("v%0d_cv0", i), int'(cv0), 1);
    chk($sformatf("v%0d_cv4", i), int'(cv4), 1);
    chk($sformatf("v%0d_class_s0", i), int'(class0), int'(vecs[i].exp0));
    chk($sformatf("v%0d_class_s4", i), int'(class4), int'(vecs[i].exp4));
    chk($sformatf("v%0d_rdy_result", i), int'(acc_ready0), 0);
`ifdef CLAS_LOGITS_EN
    for (int k = 0; k < 6; k++) begin
      int a;
      a = int'($signed(vecs[i].acc[k]));
      chk($sformatf("v%0d_logit_s0_%0d", i, k), int'(logits0[k]), a + int'(bias[k]));
      chk($sformatf("v%0d_logit_s4_%0d", i, k), int'(logits4[k]), a + int'(bias[k]) * 16);
    end
`endif
  endtask

  task automatic release_result(input string tag);
    class_ready = 1'b1;
    @(posedge clk); #1;
    class_ready = 1'b0;
    chk_idle(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bias[0] = 8'sd4;  bias[1] = -8'sd1; bias[2] = 8'sd0;
    bias[3] = -8'sd7; bias[4] = 8'sd0;  bias[5] = -8'sd6;

    set_vec(0,  0, 0, 0, 0, 0, 0,                   0, 0);
    set_vec(1,  -10, 2, 0, 0, 0, 0,                 1, 0);
    set_vec(2,  -1000, -1000, -1000, -1000, -1000, -1000, 0, 0);
    set_vec(3,  0, 5, 0, 0, 0, 0,                   0, 0);
    set_vec(4,  0, 0, 0, 0, 0, 10,                  0, 0);
    set_vec(5,  0, 0, 0, 0, 0, 11,                  5, 0);
    set_vec(6,  0, 0, 0, 0, 6, 0,                   4, 0);
    set_vec(7,  60, 0, 0, 0, 0, 0,                  0, 0);
    set_vec(8,  70, 0, 0, 0, 0, 0,                  0, 0);
    set_vec(9,  0, 20, 0, 0, 0, 0,                  1, 0);
    set_vec(10, 0, 0, 524287, 0, 0, 0,              2, 2);
    set_vec(11, -524288, -524288, -524288, -524288, -524288, -524288, 0, 0);
    set_vec(12, 0, 100, 0, 0, 0, 0,                 1, 1);
    set_vec(13, 0, 0, 0, 0, 0, 200,                 5, 5);
    set_vec(14, 0, 0, 90, 0, 0, 0,                  2, 2);
    set_vec(15, 0, 0, 0, 20, 0, 0,                  3, 0);

    #12;
    chk_idle("reset");
    chk("reset_class0", int'(class0), 0);
    chk("lut_addr", int'(lut_addr0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      run_frame(i, 1'b0);
      release_result($sformatf("v%0d_release", i));
    end

    // Mid-frame acc_valid gaps with junk data must not disturb the result.
    run_frame(14, 1'b1);
    release_result("gap_release");

    // Result held under backpressure while a new beat is pending.
    run_frame(1, 1'b0);
    acc_valid = 1'b1;
    acc_data  = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_cv", c), int'(cv0), 1);
      chk($sformatf("bp%0d_class", c), int'(class0), 1);
      chk($sformatf("bp%0d_rdy", c), int'(acc_ready0), 0);
    end
    class_ready = 1'b1;
    @(posedge clk); #1;
    class_ready = 1'b0;
    chk("bp_hs_cv", int'(cv0), 0);
    chk("bp_hs_busy", int'(busy0), 0);
    run_frame(13, 1'b0);
    release_result("bp_next_release");

    // Reset three beats into a frame; next frame starts again at class 0.
    run_frame(13, 1'b0);
    release_result("pre_rst_release");
    for (int k = 0; k < 3; k++) begin
      acc_valid = 1'b1;
      acc_data  = 20'sd1000;
      @(posedge clk); #1;
    end
    acc_valid = 1'b0;
    chk("mid_busy", int'(busy0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_class0", int'(class0), 0);
    chk("async_rst_class4", int'(class4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(15, 1'b0);
    release_result("post_rst_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
